// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART FIFO write/read controllers.
package uart_fifo_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 256;
    localparam int BATCH_LEN_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } fifo_wr_state_t;

endpackage

// File: rtl/fifo_wr_batch_tmr.sv
// Counts bytes written into the FIFO and announces a batch when it reaches
// BATCH_LEN bytes, or when a partial batch has been idle for IDLE_TIMEOUT cycles.
module fifo_wr_batch_tmr #(
    parameter int BATCH_LEN    = 16,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int LEN_W        = 9
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             wr_pulse,
    output logic             batch_rdy,
    output logic [LEN_W-1:0] batch_len
);

    localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);

    logic [LEN_W-1:0] byte_cnt_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic             batch_rdy_reg;
    logic [LEN_W-1:0] batch_len_reg;

    // A write always clears the timer, so the two flush causes are mutually exclusive.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_cnt_reg  <= '0;
            tmr_reg       <= '0;
            batch_rdy_reg <= 1'b0;
            batch_len_reg <= '0;
        end else begin
            batch_rdy_reg <= 1'b0;
            batch_len_reg <= '0;
            if (wr_pulse) begin
                tmr_reg <= '0;
                if (byte_cnt_reg == LEN_W'(BATCH_LEN - 1)) begin
                    batch_rdy_reg <= 1'b1;
                    batch_len_reg <= LEN_W'(BATCH_LEN);
                    byte_cnt_reg  <= '0;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end else if (byte_cnt_reg != '0) begin
                if (tmr_reg == TMR_W'(IDLE_TIMEOUT - 1)) begin
                    batch_rdy_reg <= 1'b1;
                    batch_len_reg <= byte_cnt_reg;
                    byte_cnt_reg  <= '0;
                    tmr_reg       <= '0;
                end else begin
                    tmr_reg <= tmr_reg + 1'b1;
                end
            end
        end
    end

    assign batch_rdy = batch_rdy_reg;
    assign batch_len = batch_len_reg;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// UART FIFO write controller: one-byte hold buffer for backpressure, drop accounting
// and batch signalling. Define FIFO_WR_STATS_EN to implement drop_cnt/overflow.
module fifo_wr_ctrl #(
    parameter int DATA_W       = uart_fifo_pkg::DATA_W,
    parameter int FIFO_DEPTH   = uart_fifo_pkg::FIFO_DEPTH,
    parameter int BATCH_LEN    = 16,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       rx_done,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_din,
    output logic                       batch_rdy,
    output logic [$clog2(FIFO_DEPTH):0] batch_len,
    output logic [15:0]                drop_cnt,
    output logic                       overflow
);

    import uart_fifo_pkg::*;

    localparam int LEN_W = $clog2(FIFO_DEPTH) + 1;

    fifo_wr_state_t    state_reg, state_next;
    logic              wr_en_reg, wr_en_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic              hold_valid_reg, hold_valid_next;
    logic [DATA_W-1:0] hold_data_reg, hold_data_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            wr_en_reg      <= 1'b0;
            din_reg        <= '0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            wr_en_reg      <= wr_en_next;
            din_reg        <= din_next;
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rx_done) state_next = fifo_full ? HOLD : GAP;
            HOLD:    if (!fifo_full) state_next = GAP;
            GAP:     state_next = hold_valid_next ? HOLD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // In HOLD the hold slot is released first, so a byte arriving in the same
    // cycle as the held byte's write takes its place instead of being dropped.
    always_comb begin
        wr_en_next      = 1'b0;
        din_next        = din_reg;
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        case (state_reg)
            IDLE: begin
                if (rx_done && !fifo_full) begin
                    wr_en_next = 1'b1;
                    din_next   = rx_data;
                end else if (rx_done) begin
                    hold_valid_next = 1'b1;
                    hold_data_next  = rx_data;
                end
            end
            HOLD: begin
                if (!fifo_full) begin
                    wr_en_next      = 1'b1;
                    din_next        = hold_data_reg;
                    hold_valid_next = 1'b0;
                end
                if (rx_done && !hold_valid_next) begin
                    hold_valid_next = 1'b1;
                    hold_data_next  = rx_data;
                end
            end
            GAP: begin
                if (rx_done && !hold_valid_reg) begin
                    hold_valid_next = 1'b1;
                    hold_data_next  = rx_data;
                end
            end
            default: ;
        endcase
    end

    assign fifo_wr_en = wr_en_reg;
    assign fifo_din   = din_reg;

`ifdef FIFO_WR_STATS_EN
    logic        byte_drop;
    logic [15:0] drop_cnt_reg;
    logic        overflow_reg;

    assign byte_drop = rx_done && ((state_reg == HOLD && fifo_full) ||
                                   (state_reg == GAP && hold_valid_reg));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (byte_drop) begin
            if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
            overflow_reg <= 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
    assign overflow = overflow_reg;
`else
    assign drop_cnt = '0;
    assign overflow = 1'b0;
`endif

    fifo_wr_batch_tmr #(
        .BATCH_LEN    (BATCH_LEN),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .LEN_W        (LEN_W)
    ) u_batch_tmr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_pulse  (wr_en_reg),
        .batch_rdy (batch_rdy),
        .batch_len (batch_len)
    );

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed testbench for fifo_wr_ctrl; expectations follow FIFO_WR_STATS_EN when defined.
module tb_fifo_wr_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       fifo_full = 1'b0;
    logic       fifo_wr_en;
    logic [7:0] fifo_din;
    logic       batch_rdy;
    logic [8:0] batch_len;
    logic [15:0] drop_cnt;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] wr_q[$];
    int         wr_cyc_q[$];
    logic [8:0] bl_q[$];
    int         bl_cyc_q[$];

    fifo_wr_ctrl #(
        .DATA_W(8), .FIFO_DEPTH(256), .BATCH_LEN(16), .IDLE_TIMEOUT(1000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .batch_rdy (batch_rdy),
        .batch_len (batch_len),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write/batch monitor on the falling edge; also guards the FIFO protocol.
    always @(negedge sys_clk) begin
        if (fifo_wr_en) begin
            check("wr_while_full", {31'd0, fifo_full}, 32'd0);
            check("wr_back_to_back", {31'd0, prev_wr}, 32'd0);
            wr_q.push_back(fifo_din);
            wr_cyc_q.push_back(cyc);
            $display("write  cyc=%0d din=%02h", cyc, fifo_din);
        end
        if (batch_rdy) begin
            bl_q.push_back(batch_len);
            bl_cyc_q.push_back(cyc);
            $display("batch  cyc=%0d len=%0d", cyc, batch_len);
        end
        prev_wr = fifo_wr_en;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        step();
        rx_done = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, {31'd0, fifo_wr_en}, 32'd0);
        check({tag, "_din"}, {24'd0, fifo_din}, 32'd0);
        check({tag, "_batch_rdy"}, {31'd0, batch_rdy}, 32'd0);
        check({tag, "_batch_len"}, {23'd0, batch_len}, 32'd0);
        check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (wr_q.size() > i) ? {24'd0, wr_q[i]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] bl_at(input int i);
        return (bl_q.size() > i) ? {23'd0, bl_q[i]} : 32'hxxxxxxxx;
    endfunction

    initial begin
        int d;
        // Reset state
        step(); step();
        sys_rst_n = 1'b1;
        step();
        check_all_zero("reset");

        // T1: single byte, FIFO not full
        rx_done = 1'b1; rx_data = 8'hA5;
        step();
        rx_done = 1'b0;
        check("t1_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        check("t1_din", {24'd0, fifo_din}, 32'hA5);
        step();
        check("t1_wr_off", {31'd0, fifo_wr_en}, 32'd0);
        step();

        // T3: back-to-back pulses
        wr_q.delete(); wr_cyc_q.delete();
        rx_done = 1'b1; rx_data = 8'h01;
        step();
        rx_data = 8'h02;
        step();
        rx_done = 1'b0;
        repeat (6) step();
        check("t3_nwr", wr_q.size(), 2);
        check("t3_d0", wr_at(0), 32'h01);
        check("t3_d1", wr_at(1), 32'h02);
        d = (wr_cyc_q.size() == 2) ? wr_cyc_q[1] - wr_cyc_q[0] : -1;
        check("t3_spacing", d, 2);
        check("t3_drop", {16'd0, drop_cnt}, 32'd0);

        // T2: full FIFO, hold one byte, drop the next
        wr_q.delete(); wr_cyc_q.delete();
        fifo_full = 1'b1;
        rx_done = 1'b1; rx_data = 8'h11;
        step();
        rx_data = 8'h22;
        step();
        rx_done = 1'b0;
        repeat (3) step();
        check("t2_nwr_full", wr_q.size(), 0);
`ifdef FIFO_WR_STATS_EN
        check("t2_drop", {16'd0, drop_cnt}, 32'd1);
        check("t2_ovf", {31'd0, overflow}, 32'd1);
`else
        check("t2_drop", {16'd0, drop_cnt}, 32'd0);
        check("t2_ovf", {31'd0, overflow}, 32'd0);
`endif
        fifo_full = 1'b0;
        repeat (6) step();
        check("t2_nwr", wr_q.size(), 1);
        check("t2_d0", wr_at(0), 32'h11);

        // T5: drop saturation (first byte goes to hold, the rest drop)
        fifo_full = 1'b1;
        rx_done = 1'b1; rx_data = 8'h33;
        step();
        for (int i = 0; i < 100; i++) begin
            rx_data = 8'(i);
            step();
        end
        rx_done = 1'b0;
        step();
`ifdef FIFO_WR_STATS_EN
        check("t5_drop101", {16'd0, drop_cnt}, 32'd101);
`else
        check("t5_drop101", {16'd0, drop_cnt}, 32'd0);
`endif
        rx_done = 1'b1;
        repeat (69900) step();
        rx_done = 1'b0;
        step();
`ifdef FIFO_WR_STATS_EN
        check("t5_drop_sat", {16'd0, drop_cnt}, 32'hFFFF);
        check("t5_ovf", {31'd0, overflow}, 32'd1);
`else
        check("t5_drop_sat", {16'd0, drop_cnt}, 32'd0);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
`endif
        // The 4 bytes written so far were flushed by the idle timer meanwhile.
        check("t5_tmo_nbatch", bl_q.size(), 1);
        check("t5_tmo_len", bl_at(0), 32'd4);

        // Reset with a held byte: it must never be written.
        wr_q.delete(); wr_cyc_q.delete(); bl_q.delete(); bl_cyc_q.delete();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        fifo_full = 1'b0;
        repeat (5) step();
        check("rst_no_stale_wr", wr_q.size(), 0);
        check("rst_no_batch", bl_q.size(), 0);

        // T4: full batch of 16
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
        repeat (3) step();
        check("t4_nwr", wr_q.size(), 16);
        check("t4_d15", wr_at(15), 32'h4F);
        check("t4_nbatch", bl_q.size(), 1);
        check("t4_len", bl_at(0), 32'd16);
        d = (bl_cyc_q.size() > 0 && wr_cyc_q.size() > 0) ? bl_cyc_q[0] - wr_cyc_q[$] : -1;
        check("t4_lat", d, 1);

        // T4b: partial batch flushed by idle timeout
        wr_q.delete(); wr_cyc_q.delete(); bl_q.delete(); bl_cyc_q.delete();
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
        for (int k = 0; k < 1200 && bl_q.size() == 0; k++) step();
        step();
        check("t4b_nbatch", bl_q.size(), 1);
        check("t4b_len", bl_at(0), 32'd5);
        d = (bl_cyc_q.size() > 0 && wr_cyc_q.size() > 0) ? bl_cyc_q[0] - wr_cyc_q[$] : -1;
        check("t4b_lat_window", {31'd0, (d >= 1000 && d <= 1002)}, 32'd1);

        // T6: async reset with 7 bytes counted and a held byte
        wr_q.delete(); wr_cyc_q.delete(); bl_q.delete(); bl_cyc_q.delete();
        for (int i = 0; i < 7; i++) send(8'h70 + 8'(i));
        fifo_full = 1'b1;
        rx_done = 1'b1; rx_data = 8'hEE;
        step();
        rx_data = 8'hEF;
        step();
        rx_done = 1'b0;
        step();
`ifdef FIFO_WR_STATS_EN
        check("t6_pre_drop", {16'd0, drop_cnt}, 32'd1);
`else
        check("t6_pre_drop", {16'd0, drop_cnt}, 32'd0);
`endif
        check("t6_pre_din", {24'd0, fifo_din}, 32'h76);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        wr_q.delete(); wr_cyc_q.delete();
        step(); step();
        sys_rst_n = 1'b1;
        fifo_full = 1'b0;
        repeat (5) step();
        check("t6_no_stale_wr", wr_q.size(), 0);
        check("t6_no_batch", bl_q.size(), 0);
        for (int i = 0; i < 9; i++) send(8'h80 + 8'(i));
        repeat (3) step();
        check("t6_no_early_batch", bl_q.size(), 0);
        for (int i = 9; i < 16; i++) send(8'h80 + 8'(i));
        repeat (3) step();
        check("t6_nbatch", bl_q.size(), 1);
        check("t6_len", bl_at(0), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
